// File: rtl/ulx3s_pll_lock_supervisor.sv
// rtl/ulx3s_pll_lock_supervisor.sv - ECP5 EHXPLLL reset/lock supervisor with staggered downstream reset release
// Optional RUN-state lock-loss glitch filter enabled by defining ULX3S_PLL_SUP_GLITCH_FILTER_EN.
module ulx3s_pll_lock_supervisor #(
  parameter int NUM_RST            = 2,
  parameter int PLL_RST_CYCLES     = 8,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGGER_CYCLES     = 16,
  parameter int RELOCK_TIMEOUT     = 65536,
  parameter int GLITCH_CYCLES      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pll_locked_in,
  output logic               pll_rst,
  output logic [NUM_RST-1:0] rst_out,
  output logic               ready,
  output logic [7:0]         relock_count,
  output logic               timeout_err
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int RELEASE_SPAN = (NUM_RST - 1) * STAGGER_CYCLES;
  localparam int MAX_TERM = max2(max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                      max2(RELOCK_TIMEOUT, RELEASE_SPAN)), GLITCH_CYCLES);
  localparam int CW = $clog2(MAX_TERM) + 1;

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t RST_LAST     = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t WAIT_LAST    = cnt_t'(RELOCK_TIMEOUT - 1);
  localparam cnt_t STABLE_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
  // A single reset output still spends one cycle in RELEASE before RUN.
  localparam cnt_t RELEASE_LAST = cnt_t'((NUM_RST == 1) ? 0 : RELEASE_SPAN - 1);
`ifdef ULX3S_PLL_SUP_GLITCH_FILTER_EN
  localparam cnt_t GLITCH_LAST  = cnt_t'(GLITCH_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  logic [1:0]         sync_q;
  logic               locked_s;
  state_t             state;
  state_t             state_n;
  cnt_t               cnt;
  cnt_t               cnt_n;
  cnt_t               cnt_inc;
  logic               lock_lost;
  logic               wait_expired;
  logic               pll_rst_n;
  logic               ready_n;
  logic               timeout_n;
  logic [NUM_RST-1:0] rst_out_n;
  logic [7:0]         relock_n;

  assign locked_s = sync_q[1];
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + cnt_t'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked_in};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= PLL_RESET;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt_inc;
    lock_lost    = 1'b0;
    wait_expired = 1'b0;
    unique case (state)
      PLL_RESET: begin
        if (cnt == RST_LAST) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a timeout expiring in the same cycle.
        if (locked_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt == WAIT_LAST) begin
          state_n      = PLL_RESET;
          cnt_n        = '0;
          wait_expired = 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end
      end
      RELEASE: begin
        if (!locked_s) begin
          state_n   = PLL_RESET;
          cnt_n     = '0;
          lock_lost = 1'b1;
        end else if (cnt == RELEASE_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
`ifdef ULX3S_PLL_SUP_GLITCH_FILTER_EN
        // In RUN the counter tracks consecutive cycles of lost lock.
        if (!locked_s) begin
          if (cnt == GLITCH_LAST) begin
            state_n   = PLL_RESET;
            cnt_n     = '0;
            lock_lost = 1'b1;
          end
        end else begin
          cnt_n = '0;
        end
`else
        cnt_n = '0;
        if (!locked_s) begin
          state_n   = PLL_RESET;
          lock_lost = 1'b1;
        end
`endif
      end
      default: begin
        state_n = PLL_RESET;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    pll_rst_n = (state_n == PLL_RESET);
    ready_n   = (state_n == RUN);
    rst_out_n = '1;
    for (int i = 0; i < NUM_RST; i++) begin
      rst_out_n[i] = !((state_n == RUN) ||
                       ((state_n == RELEASE) && (cnt_n >= cnt_t'(i * STAGGER_CYCLES))));
    end
    relock_n  = (lock_lost && (relock_count != 8'hFF)) ? relock_count + 8'd1 : relock_count;
    timeout_n = timeout_err | wait_expired;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pll_rst      <= 1'b1;
      rst_out      <= '1;
      ready        <= 1'b0;
      relock_count <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      pll_rst      <= pll_rst_n;
      rst_out      <= rst_out_n;
      ready        <= ready_n;
      relock_count <= relock_n;
      timeout_err  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_ulx3s_pll_lock_supervisor.sv
// tb/tb_ulx3s_pll_lock_supervisor.sv - self-checking bench for ulx3s_pll_lock_supervisor
// Honours ULX3S_PLL_SUP_GLITCH_FILTER_EN when defined for the whole build.
module tb_ulx3s_pll_lock_supervisor;
  localparam int NR  = 3;
  localparam int PRC = 3;
  localparam int LSC = 8;
  localparam int STG = 4;
  localparam int TO  = 32;
  localparam int GC  = 4;
  localparam int REL_LEN = (NR == 1) ? 1 : (NR - 1) * STG;
`ifdef ULX3S_PLL_SUP_GLITCH_FILTER_EN
  localparam int DIP_LIMIT = GC;
`else
  localparam int DIP_LIMIT = 1;
`endif
  localparam int MP_RST  = 0;
  localparam int MP_WAIT = 1;
  localparam int MP_STB  = 2;
  localparam int MP_REL  = 3;
  localparam int MP_RUN  = 4;

  typedef struct {
    logic       rs;
    logic       lk;
    logic       pll;
    logic [2:0] ro;
    logic       rdy;
  } vec_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          pll_locked_in;
  logic          pll_rst;
  logic [NR-1:0] rst_out;
  logic          ready;
  logic [7:0]    relock_count;
  logic          timeout_err;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic hist[$];
  int   m_phase  = MP_RST;
  int   m_el     = 0;
  int   m_dip    = 0;
  int   m_relock = 0;
  logic m_terr   = 1'b0;
  vec_t tbl[32];

  ulx3s_pll_lock_supervisor #(
    .NUM_RST(NR), .PLL_RST_CYCLES(PRC), .LOCK_STABLE_CYCLES(LSC),
    .STAGGER_CYCLES(STG), .RELOCK_TIMEOUT(TO), .GLITCH_CYCLES(GC)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked_in(pll_locked_in), .pll_rst(pll_rst),
    .rst_out(rst_out), .ready(ready), .relock_count(relock_count), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [13:0] pk(input logic p, input logic [2:0] r, input logic y,
                                     input logic [7:0] c, input logic t);
    return {p, r, y, c, t};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {pll_rst, rst_out, ready, relock_count, timeout_err};
  endfunction

  // Outputs follow from the current phase and how long it has lasted.
  function automatic logic [13:0] model_vec();
    logic [2:0] ro;
    for (int i = 0; i < NR; i++)
      ro[i] = !(m_phase == MP_RUN || (m_phase == MP_REL && m_el >= i * STG));
    return {m_phase == MP_RST, ro, m_phase == MP_RUN, 8'(m_relock), m_terr};
  endfunction

  task automatic model_abort();
    m_phase = MP_RST;
    m_el    = 0;
    m_dip   = 0;
    if (m_relock < 255) m_relock++;
  endtask

  task automatic model_edge(input logic lk, input logic rs);
    logic ls;
    ls = hist[0];
    hist.delete(0);
    hist.push_back(lk);
    if (rs) begin
      hist.delete();
      hist.push_back(1'b0);
      hist.push_back(1'b0);
      m_phase = MP_RST; m_el = 0; m_dip = 0; m_relock = 0; m_terr = 1'b0;
    end else begin
      case (m_phase)
        MP_RST: begin
          if (m_el + 1 == PRC) begin m_phase = MP_WAIT; m_el = 0; end
          else m_el++;
        end
        MP_WAIT: begin
          if (ls) begin m_phase = MP_STB; m_el = 0; end
          else if (m_el + 1 == TO) begin m_phase = MP_RST; m_el = 0; m_terr = 1'b1; end
          else m_el++;
        end
        MP_STB: begin
          if (!ls) begin m_phase = MP_WAIT; m_el = 0; end
          else if (m_el + 1 == LSC) begin m_phase = MP_REL; m_el = 0; end
          else m_el++;
        end
        MP_REL: begin
          if (!ls) model_abort();
          else if (m_el + 1 == REL_LEN) begin m_phase = MP_RUN; m_el = 0; end
          else m_el++;
        end
        default: begin
          m_dip = ls ? 0 : m_dip + 1;
          if (m_dip >= DIP_LIMIT) model_abort();
        end
      endcase
    end
  endtask

  task automatic step(input logic lk, input logic rs);
    pll_locked_in = lk;
    reset = rs;
    @(posedge clock);
    model_edge(lk, rs);
    @(negedge clock);
    cyc++;
    chk("model", 16'(dut_vec()), 16'(model_vec()));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic rlk;
    int   len;
    int   n;
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    reset = 1'b1;
    pll_locked_in = 1'b0;

    // Reset, then lock from cycle 10: release at 20/24/28.
    for (int r = 0; r < 32; r++) begin
      tbl[r].rs  = (r == 0);
      tbl[r].lk  = (r >= 10);
      tbl[r].pll = (r <= 2);
      tbl[r].ro  = (r < 20) ? 3'b111 : (r < 24) ? 3'b110 : (r < 28) ? 3'b100 : 3'b000;
      tbl[r].rdy = (r >= 28);
    end
    for (int r = 0; r < 32; r++) begin
      step(tbl[r].lk, tbl[r].rs);
      chk("table", 16'(dut_vec()), 16'(pk(tbl[r].pll, tbl[r].ro, tbl[r].rdy, 8'd0, 1'b0)));
    end

    // Lock never rises: pll_rst pulses at 0, 35, 70.
    step(1'b0, 1'b1);
    for (int p = 1; p <= 75; p++) begin
      step(1'b0, 1'b0);
      case (p)
        34: chk("to_before", 16'(dut_vec()), 16'(pk(1'b0, 3'b111, 1'b0, 8'd0, 1'b0)));
        35: chk("to_expire", 16'(dut_vec()), 16'(pk(1'b1, 3'b111, 1'b0, 8'd0, 1'b1)));
        37: chk("to_pulse_end", 16'(dut_vec()), 16'(pk(1'b1, 3'b111, 1'b0, 8'd0, 1'b1)));
        38: chk("to_pulse_off", 16'(dut_vec()), 16'(pk(1'b0, 3'b111, 1'b0, 8'd0, 1'b1)));
        69: chk("to_second_wait", 16'(dut_vec()), 16'(pk(1'b0, 3'b111, 1'b0, 8'd0, 1'b1)));
        70: chk("to_second_pulse", 16'(dut_vec()), 16'(pk(1'b1, 3'b111, 1'b0, 8'd0, 1'b1)));
        default: ;
      endcase
    end

    // Lock arriving in the very cycle the timeout expires wins.
    step(1'b0, 1'b1);
    for (int p = 1; p <= 43; p++) begin
      step(p >= 33, 1'b0);
      if (p == 35) chk("tie_lock_wins", 16'(dut_vec()), 16'(pk(1'b0, 3'b111, 1'b0, 8'd0, 1'b0)));
      if (p == 43) chk("tie_release", 16'(dut_vec()), 16'(pk(1'b0, 3'b110, 1'b0, 8'd0, 1'b0)));
    end
    step(1'b0, 1'b1);
    for (int p = 1; p <= 36; p++) begin
      step(p >= 34, 1'b0);
      if (p == 35) chk("tie_late_lock", 16'(dut_vec()), 16'(pk(1'b1, 3'b111, 1'b0, 8'd0, 1'b1)));
    end

    // One-cycle dip in STABLE restarts the stable count only.
    step(1'b0, 1'b1);
    for (int p = 1; p <= 34; p++) begin
      step(p >= 10 && p != 15, 1'b0);
      case (p)
        17: chk("stb_dip_wait", 16'(dut_vec()), 16'(pk(1'b0, 3'b111, 1'b0, 8'd0, 1'b0)));
        20: chk("stb_no_early", 16'(dut_vec()), 16'(pk(1'b0, 3'b111, 1'b0, 8'd0, 1'b0)));
        25: chk("stb_restart", 16'(dut_vec()), 16'(pk(1'b0, 3'b111, 1'b0, 8'd0, 1'b0)));
        26: chk("stb_release", 16'(dut_vec()), 16'(pk(1'b0, 3'b110, 1'b0, 8'd0, 1'b0)));
        33: chk("stb_stagger", 16'(dut_vec()), 16'(pk(1'b0, 3'b100, 1'b0, 8'd0, 1'b0)));
        34: chk("stb_run", 16'(dut_vec()), 16'(pk(1'b0, 3'b000, 1'b1, 8'd0, 1'b0)));
        default: ;
      endcase
    end

`ifdef ULX3S_PLL_SUP_GLITCH_FILTER_EN
    // 3-cycle dip ignored, 4-cycle dip aborts.
    step(1'b0, 1'b1);
    for (int p = 1; p <= 46; p++) begin
      step(p >= 10 && !(p >= 30 && p <= 32) && !(p >= 40 && p <= 43), 1'b0);
      case (p)
        36: chk("flt_short_dip", 16'(dut_vec()), 16'(pk(1'b0, 3'b000, 1'b1, 8'd0, 1'b0)));
        44: chk("flt_long_pending", 16'(dut_vec()), 16'(pk(1'b0, 3'b000, 1'b1, 8'd0, 1'b0)));
        45: chk("flt_long_abort", 16'(dut_vec()), 16'(pk(1'b1, 3'b111, 1'b0, 8'd1, 1'b0)));
        default: ;
      endcase
    end
`else
    // Single-cycle loss in RUN aborts, then a normal relock follows.
    step(1'b0, 1'b1);
    for (int p = 1; p <= 52; p++) begin
      step(p >= 10 && p != 30, 1'b0);
      case (p)
        31: chk("run_before_loss", 16'(dut_vec()), 16'(pk(1'b0, 3'b000, 1'b1, 8'd0, 1'b0)));
        32: chk("run_abort", 16'(dut_vec()), 16'(pk(1'b1, 3'b111, 1'b0, 8'd1, 1'b0)));
        34: chk("run_pulse_end", 16'(dut_vec()), 16'(pk(1'b1, 3'b111, 1'b0, 8'd1, 1'b0)));
        35: chk("run_pulse_off", 16'(dut_vec()), 16'(pk(1'b0, 3'b111, 1'b0, 8'd1, 1'b0)));
        44: chk("run_rerelease", 16'(dut_vec()), 16'(pk(1'b0, 3'b110, 1'b0, 8'd1, 1'b0)));
        52: chk("run_rerun", 16'(dut_vec()), 16'(pk(1'b0, 3'b000, 1'b1, 8'd1, 1'b0)));
        default: ;
      endcase
    end
`endif

    // 260 forced losses saturate relock_count; reset inside RELEASE clears everything.
    step(1'b0, 1'b1);
    for (int it = 0; it < 260; it++) begin
      for (int k = 0; k < 30; k++) step(1'b1, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
    end
    chk("relock_sat", 16'(relock_count), 16'd255);
    n = 0;
    while (m_phase != MP_REL && n < 60) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("reach_release", 16'(rst_out), 16'(3'b110));
    step(1'b1, 1'b1);
    chk("reset_in_release", 16'(dut_vec()), 16'(pk(1'b1, 3'b111, 1'b0, 8'd0, 1'b0)));

    // Random lock segments with rare resets, checked against the model every cycle.
    for (int seg = 0; seg < 150; seg++) begin
      rlk = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 45));
      for (int k = 0; k < len; k++) step(rlk, $urandom_range(0, 399) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
